// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter.
//   arb_state_e    : arbiter FSM states
//   M1 / M2        : master IDs, also the master_sel mux encoding
//   DEF_BURST_LEN  : default beats per tenure
//   DEF_TIMEOUT    : default watchdog limit in cycles between beats
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT1  = 2'd1,
        GRANT2  = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam logic M1 = 1'b0;
    localparam logic M2 = 1'b1;

    localparam int DEF_BURST_LEN = 16;
    localparam int DEF_TIMEOUT   = 1000;

endpackage

// File: rtl/arb_watchdog.sv
// Per-beat watchdog for the bus arbiter.
// Counts cycles since the last clear and flags expiry once the count
// reaches TIMEOUT. The count saturates at TIMEOUT so it cannot wrap.
// Ports:
//   clk      in  bus clock
//   reset    in  asynchronous active-low reset
//   clr_i    in  synchronous clear (has priority over en_i)
//   en_i     in  count enable
//   expire_o out high while the count equals TIMEOUT
module arb_watchdog
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter. Grants bus tenure to master 1 or master 2 for
// one burst of up to BURST_LEN beats, inserts one RELEASE turnaround cycle
// between tenures, and aborts a tenure whose slave stalls for TIMEOUT
// cycles between beats.
//
// Request/grant handshake: a master raises its req and holds it high for
// the whole tenure; the grant rises on the edge that samples the request
// and stays high until the burst completes, the master drops req, or the
// watchdog fires. beat_done is only honoured while a grant is active.
//
// Configuration macro: ROUND_ROBIN_EN. When defined, a tie goes to the
// master that did not own the previous tenure (master 1 wins the first
// tie after reset). When undefined, master 1 always wins a tie.
//
// Ports:
//   clk          in  bus clock
//   reset        in  asynchronous active-low reset
//   m1_req       in  master 1 request
//   m2_req       in  master 2 request
//   beat_done    in  one-cycle pulse per completed data beat
//   m1_grant     out master 1 owns the bus
//   m2_grant     out master 2 owns the bus
//   master_sel   out mux select (0 = master 1, 1 = master 2), held between tenures
//   bus_busy     out FSM not in IDLE
//   burst_last   out current beat is the final beat of the burst
//   timeout_err  out one-cycle pulse when the watchdog aborts a tenure
//   dbg_state_o  out current FSM state
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       beat_done,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       master_sel,
    output logic       bus_busy,
    output logic       burst_last,
    output logic       timeout_err,
    output logic [1:0] dbg_state_o
);

    localparam int CW = $clog2(BURST_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] beat_q, beat_d;
    logic          sel_q, sel_d;
    logic          terr_q, terr_d;
    logic          granted;
    logic          own_req;
    logic          tie_pick;
    logic          wd_expire;

    assign granted = (state_q == GRANT1) || (state_q == GRANT2);
    assign own_req = (state_q == GRANT1) ? m1_req : m2_req;

`ifdef ROUND_ROBIN_EN
    // Owner of the previous tenure; resets to M2 so master 1 wins the first tie.
    logic last_owner_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_q <= M2;
        end else if ((state_q == IDLE) && (state_d != IDLE)) begin
            last_owner_q <= sel_d;
        end
    end

    assign tie_pick = (last_owner_q == M2) ? M1 : M2;
`else
    assign tie_pick = M1;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        sel_d   = sel_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (m1_req && m2_req) begin
                    state_d = (tie_pick == M1) ? GRANT1 : GRANT2;
                    sel_d   = tie_pick;
                end else if (m1_req) begin
                    state_d = GRANT1;
                    sel_d   = M1;
                end else if (m2_req) begin
                    state_d = GRANT2;
                    sel_d   = M2;
                end
            end
            GRANT1, GRANT2: begin
                if (beat_done) begin
                    beat_d = beat_q + 1'b1;
                end
                // Watchdog abort wins over the other end-of-tenure causes so
                // the error pulse is never lost.
                if (wd_expire) begin
                    state_d = RELEASE;
                    terr_d  = 1'b1;
                end else if (!own_req || (beat_done && (beat_q == LAST_BEAT))) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                beat_d  = '0;
                state_d = IDLE;
            end
            default: begin
                beat_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            sel_q   <= M1;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            sel_q   <= sel_d;
            terr_q  <= terr_d;
        end
    end

    // Held clear outside a grant, so every tenure starts from zero.
    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (!granted || beat_done),
        .en_i     (granted),
        .expire_o (wd_expire)
    );

    assign m1_grant    = (state_q == GRANT1);
    assign m2_grant    = (state_q == GRANT2);
    assign master_sel  = sel_q;
    assign bus_busy    = (state_q != IDLE);
    assign burst_last  = granted && (beat_q == LAST_BEAT);
    assign timeout_err = terr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by a
// randomized run, all compared every cycle against a behavioural model.
module tb_bus_arbiter;

    localparam int BL = 16;
    localparam int TO = 1000;

    logic       clk;
    logic       reset;
    logic       m1_req, m2_req, beat_done;
    logic       m1_grant, m2_grant, master_sel, bus_busy, burst_last, timeout_err;
    logic [1:0] dbg_state;

    int vectors;
    int miscompares;

    // Behavioural model: who owns the bus (0 none, 1, 2), whether the
    // turnaround cycle is in progress, beats taken and cycles since last beat.
    int m_own, m_rel, m_beats, m_wd, m_last, m_sel, m_terr;
    bit rr;

    bus_arbiter #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .m1_req      (m1_req),
        .m2_req      (m2_req),
        .beat_done   (beat_done),
        .m1_grant    (m1_grant),
        .m2_grant    (m2_grant),
        .master_sel  (master_sel),
        .bus_busy    (bus_busy),
        .burst_last  (burst_last),
        .timeout_err (timeout_err),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_reset();
        m_own = 0; m_rel = 0; m_beats = 0; m_wd = 0; m_sel = 0; m_terr = 0;
        m_last = 2;
    endtask

    task automatic model_step(input bit r1, input bit r2, input bit bd);
        int win;
        bit req;
        m_terr = 0;
        if (m_rel != 0) begin
            m_rel = 0;
        end else if (m_own == 0) begin
            win = 0;
            if (r1 && r2) win = rr ? ((m_last == 2) ? 1 : 2) : 1;
            else if (r1) win = 1;
            else if (r2) win = 2;
            if (win != 0) begin
                m_own = win; m_sel = win - 1; m_last = win;
                m_beats = 0; m_wd = 0;
            end
        end else begin
            req = (m_own == 1) ? r1 : r2;
            if (m_wd >= TO) begin
                m_terr = 1; m_own = 0; m_rel = 1;
            end else if (!req || (bd && m_beats == BL - 1)) begin
                m_own = 0; m_rel = 1;
            end else if (bd) begin
                m_beats++; m_wd = 0;
            end else begin
                m_wd++;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag);
        logic [5:0] obs, exp;
        logic       excl_ok, busy_state;
        obs = {m1_grant, m2_grant, master_sel, bus_busy, burst_last, timeout_err};
        exp = {m_own == 1, m_own == 2, m_sel[0], (m_own != 0) || (m_rel != 0),
               (m_own != 0) && (m_beats == BL - 1), m_terr[0]};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s outputs {g1,g2,sel,busy,last,terr}: observed %b expected %b", tag, obs, exp);
        end
        excl_ok = !(m1_grant && m2_grant) && (!m1_grant || !master_sel) && (!m2_grant || master_sel);
        vectors++;
        assert (excl_ok === 1'b1) else begin
            miscompares++;
            $error("FAIL %s exclusion: observed %b expected 1", tag, excl_ok);
        end
        busy_state = (dbg_state != 2'd0);
        vectors++;
        assert (busy_state === exp[2]) else begin
            miscompares++;
            $error("FAIL %s dbg_state busy: observed %b expected %b", tag, busy_state, exp[2]);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive, let the rising edge sample, then check.
    task automatic cycle(input string tag, input bit r1, input bit r2, input bit bd);
        m1_req = r1; m2_req = r2; beat_done = bd;
        @(posedge clk);
        model_step(r1, r2, bd);
        @(negedge clk);
        check(tag);
    endtask

    task automatic burst(input string tag, input bit r1, input bit r2, input int beats, input int gap);
        for (int b = 0; b < beats; b++) begin
            for (int g = 0; g < gap; g++) cycle(tag, r1, r2, 1'b0);
            cycle(tag, r1, r2, 1'b1);
        end
    endtask

    initial begin
        bit r1, r2, bd;
        vectors = 0; miscompares = 0;
`ifdef ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        model_reset();
        reset = 1'b0; m1_req = 1'b0; m2_req = 1'b0; beat_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset");
        reset = 1'b1;
        cycle("idle", 1'b0, 1'b0, 1'b1);

        // Single master full burst, beats 3 cycles apart.
        cycle("m1_grant", 1'b1, 1'b0, 1'b0);
        burst("m1_full", 1'b1, 1'b0, BL, 2);
        repeat (3) cycle("m1_after", 1'b0, 1'b0, 1'b0);

        // Repeated tie: three tenures with both requests held.
        for (int t = 0; t < 3; t++) begin
            cycle("tie_grant", 1'b1, 1'b1, 1'b0);
            burst("tie_burst", 1'b1, 1'b1, BL, 0);
            cycle("tie_release", 1'b1, 1'b1, 1'b0);
        end
        repeat (2) cycle("tie_after", 1'b0, 1'b0, 1'b0);

        // Early release: master 2 drops after 5 beats.
        cycle("m2_grant", 1'b0, 1'b1, 1'b0);
        burst("m2_early", 1'b0, 1'b1, 5, 1);
        repeat (4) cycle("m2_drop", 1'b0, 1'b0, 1'b0);

        // Watchdog: master 1 granted, no beats.
        repeat (TO + 6) cycle("watchdog", 1'b1, 1'b0, 1'b0);
        repeat (2) cycle("wd_drop", 1'b0, 1'b0, 1'b0);
        cycle("wd_next", 1'b0, 1'b1, 1'b0);
        burst("wd_next_burst", 1'b0, 1'b1, 3, 1);
        repeat (3) cycle("wd_next_drop", 1'b0, 1'b0, 1'b0);

        // Reset mid-burst at beat 7, checked between clock edges.
        cycle("rst_grant", 1'b1, 1'b0, 1'b0);
        burst("rst_burst", 1'b1, 1'b0, 7, 1);
        #2;
        reset = 1'b0; m1_req = 1'b0;
        #1;
        model_reset();
        check("async_reset");
        @(negedge clk);
        check("in_reset");
        reset = 1'b1;
        cycle("fresh_grant", 1'b1, 1'b0, 1'b0);
        burst("fresh_full", 1'b1, 1'b0, BL, 1);
        repeat (3) cycle("fresh_after", 1'b0, 1'b0, 1'b0);

        // Randomized requests and beats.
        r1 = 1'b0; r2 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0) r1 = ~r1;
            if ($urandom_range(0, 15) == 0) r2 = ~r2;
            bd = ($urandom_range(0, 2) == 0);
            cycle("random", r1, r2, bd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
